// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: load/store size codes
// carried on func3 and the request FSM state encoding.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for the five size codes the load/store unit is allowed to issue.
    function automatic logic isFuncDefined(input logic [2:0] f);
        return (f == F3_B) || (f == F3_H) || (f == F3_W) ||
               (f == F3_BU) || (f == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the core's right-aligned data and a 32-bit
// memory word: store byte enables and replicated write data, and load lane
// selection with sign/zero extension. Undefined size codes act as word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byteEn,
    output logic [31:0] o_wdataLane,
    output logic [31:0] o_rdataExt
);

    logic w_isByte;
    logic w_isHalf;
    logic w_isUnsigned;

    assign w_isByte     = (i_func3 == F3_B) || (i_func3 == F3_BU);
    assign w_isHalf     = (i_func3 == F3_H) || (i_func3 == F3_HU);
    assign w_isUnsigned = i_func3[2];

    // Lane steering: a half ignores lane bit 0 and a word ignores both, so
    // misaligned accesses collapse onto the aligned container.
    always_comb begin
        logic [7:0]  w_byte;
        logic [15:0] w_half;
        o_byteEn    = 4'b1111;
        o_wdataLane = i_wdata;
        o_rdataExt  = i_rword;
        w_byte      = i_rword[8*i_lane +: 8];
        w_half      = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
        if (w_isByte) begin
            o_byteEn    = 4'b0001 << i_lane;
            o_wdataLane = {4{i_wdata[7:0]}};
            o_rdataExt  = {{24{w_byte[7] & ~w_isUnsigned}}, w_byte};
        end else if (w_isHalf) begin
            o_byteEn    = i_lane[1] ? 4'b1100 : 4'b0011;
            o_wdataLane = {2{i_wdata[15:0]}};
            o_rdataExt  = {{16{w_half[15] & ~w_isUnsigned}}, w_half};
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder for the core load/store unit: captures a request,
// waits WAIT_CYCLES, then strobes ready for one cycle with load data/fault.
// Define DMEM_FAULT_CHECK_EN to enable access-fault detection; without it err
// stays 0, misaligned accesses are force-aligned and the word index wraps.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t             r_state;
    logic [3:0]         r_count;
    logic               r_we;
    logic [2:0]         r_func3;
    logic [IDX_W-1:0]   r_wordIdx;
    logic [1:0]         r_lane;
    logic [31:0]        r_wdata;
    logic               r_fault;
    logic               r_ready;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH];

    logic               w_faultIn;
    logic [31:0]        w_memWord;
    logic [3:0]         w_byteEn;
    logic [31:0]        w_wdataLane;
    logic [31:0]        w_loadData;

`ifdef DMEM_FAULT_CHECK_EN
    logic w_badFunc;
    logic w_unsignedStore;
    logic w_misalign;
    logic w_outOfRange;

    assign w_badFunc       = !isFuncDefined(func3);
    assign w_unsignedStore = we && ((func3 == F3_BU) || (func3 == F3_HU));
    assign w_misalign      = (((func3 == F3_H) || (func3 == F3_HU)) && addr[0]) ||
                             ((func3 == F3_W) && (addr[1:0] != 2'b00));
    assign w_outOfRange    = addr[31:2] >= 30'(DEPTH);
    assign w_faultIn       = w_badFunc || w_unsignedStore || w_misalign || w_outOfRange;
`else
    logic w_unusedAddrHi;
    assign w_unusedAddrHi = ^addr[31:IDX_W+2];
    assign w_faultIn      = 1'b0;
`endif

    assign w_memWord = r_mem[r_wordIdx];

    dmem_lane_align u_align (
        .i_func3     (r_func3),
        .i_lane      (r_lane),
        .i_wdata     (r_wdata),
        .i_rword     (w_memWord),
        .o_byteEn    (w_byteEn),
        .o_wdataLane (w_wdataLane),
        .o_rdataExt  (w_loadData)
    );

    // Request FSM: capture operands in IDLE, count wait states, then raise
    // ready and err for the single RESP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= 4'd0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_we      <= 1'b0;
            r_func3   <= 3'b000;
            r_wordIdx <= '0;
            r_lane    <= 2'b00;
            r_wdata   <= 32'd0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (req) begin
                        r_we      <= we;
                        r_func3   <= func3;
                        r_wordIdx <= addr[IDX_W+1:2];
                        r_lane    <= addr[1:0];
                        r_wdata   <= wdata;
                        r_fault   <= w_faultIn;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_RESP;
                            r_ready <= 1'b1;
                            r_err   <= w_faultIn;
                        end else begin
                            r_state <= ST_WAIT;
                            r_count <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_count == 4'd0) begin
                        r_state <= ST_RESP;
                        r_ready <= 1'b1;
                        r_err   <= r_fault;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Storage write on the RESP edge; reset leaves the array untouched and a
    // reset mid-access drops the FSM out of RESP so the store never lands.
    always_ff @(posedge clk) begin
        if (r_state == ST_RESP && r_we && !r_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byteEn[i]) begin
                    r_mem[r_wordIdx][8*i +: 8] <= w_wdataLane[8*i +: 8];
                end
            end
        end
    end

    assign ready = r_ready;
    assign err   = r_err;
    assign rdata = (r_ready && !r_we && !r_fault) ? w_loadData : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Three instances cover
// WAIT_CYCLES = 1, 3 and 0. Expectations come from a byte-addressed memory
// model; builds with DMEM_FAULT_CHECK_EN also exercise the fault vectors.
module tb_data_mem_responder;

    localparam int DEPTH = 64;
`ifdef DMEM_FAULT_CHECK_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset [3];
    logic        req   [3];
    logic        we    [3];
    logic [2:0]  func3 [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];

    int nChecks;
    int nFail;

    logic [7:0] modelMem [3][4*DEPTH];

    typedef struct {
        logic        w;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] d;
        logic        expErr;
        logic [31:0] expData;
        string       name;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) dutW1 (
        .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]), .func3(func3[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dutW3 (
        .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]), .func3(func3[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dutW0 (
        .clk(clk), .reset(reset[2]), .req(req[2]), .we(we[2]), .func3(func3[2]),
        .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .err(err[2])
    );

    // Free-running 100 MHz clock shared by all instances.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int waitOf(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    // Byte-addressed reference: size from func3, faults from the access
    // rules, forced alignment and modulo wrap when fault checking is off.
    function automatic void modelAccess(input int k, input logic w, input logic [2:0] f,
                                        input logic [31:0] a, input logic [31:0] d,
                                        output logic expErr, output logic [31:0] expData);
        int size;
        int word;
        int off;
        int base;
        logic [31:0] v;
        bit defined;
        defined = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
        case (f)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        expErr  = 1'b0;
        expData = 32'd0;
        if (FAULT_EN) begin
            if (!defined || (w && f[2]) || ((a % size) != 0) || ((a >> 2) >= DEPTH)) begin
                expErr = 1'b1;
                return;
            end
        end
        word = int'((a >> 2) % DEPTH);
        off  = int'(a[1:0]);
        off  = off - (off % size);
        base = word * 4 + off;
        if (w) begin
            for (int i = 0; i < size; i++) modelMem[k][base+i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = modelMem[k][base+i];
            if (size < 4 && !f[2] && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
            expData = v;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one request, scrambles the operand inputs once it has been
    // captured, and waits (bounded) for the ready strobe.
    task automatic runTxn(input int k, input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] gotData, output logic gotErr,
                          output int lat);
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; func3[k] = f; addr[k] = a; wdata[k] = d;
        lat = 0; gotData = 32'd0; gotErr = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (ready[k]) begin
                lat = c; gotData = rdata[k]; gotErr = err[k];
                break;
            end
            @(negedge clk);
            we[k] = 1'($urandom); func3[k] = 3'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
        end
        @(negedge clk);
        req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
    endtask

    // One full access with model update, response checks and an idle check.
    task automatic applyStimulus(input int k, input logic w, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] d, input string name, input bit useTable,
                                 input logic tErr, input logic [31:0] tData);
        logic [31:0] gotData;
        logic        gotErr;
        int          lat;
        logic        mErr;
        logic [31:0] mData;
        runTxn(k, w, f, a, d, gotData, gotErr, lat);
        modelAccess(k, w, f, a, d, mErr, mData);
        if (useTable) begin
            mErr  = tErr;
            mData = tData;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(waitOf(k) + 1));
        checkOutput({name, "_err"}, {31'd0, gotErr}, {31'd0, mErr});
        checkOutput({name, "_rdata"}, gotData, mData);
        @(posedge clk);
        #1;
        checkOutput({name, "_idle"}, {rdata[k][31:2], ready[k], err[k]} | {2'b00, rdata[k][1:0], 28'd0}, 32'd0);
    endtask

    function automatic void addVec(input logic w, input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] d, input logic e, input logic [31:0] r,
                                   input string n);
        vec_t v;
        v.w = w; v.f = f; v.a = a; v.d = d; v.expErr = e; v.expData = r; v.name = n;
        vecs.push_back(v);
    endfunction

    initial begin
        logic        mErr;
        logic [31:0] mData;
        nChecks = 0;
        nFail   = 0;
        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; func3[k] = 3'b010;
            addr[k] = 32'd0; wdata[k] = 32'd0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_outputs", {rdata[k][31:2], ready[k], err[k]} | {2'b00, rdata[k][1:0], 28'd0}, 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;

        // Fill every word so model and storage start from known data
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                applyStimulus(k, 1'b1, 3'b010, 32'(4*i), $urandom, "init_sw", 1'b0, 1'b0, 32'd0);
            end
        end

        // Directed vectors on the WAIT_CYCLES=1 instance
        addVec(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        "sw_deadbeef");
        addVec(1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, "lw_deadbeef");
        addVec(1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'h0,        "sw_11223344");
        addVec(1'b1, 3'b000, 32'h13, 32'h00000080, 1'b0, 32'h0,        "sb_80");
        addVec(1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFFFF80, "lb_13");
        addVec(1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h00000080, "lbu_13");
        addVec(1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h80223344, "lw_after_sb");
        addVec(1'b1, 3'b001, 32'h12, 32'h00008001, 1'b0, 32'h0,        "sh_8001");
        addVec(1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFF8001, "lh_12");
        addVec(1'b0, 3'b101, 32'h12, 32'h0,        1'b0, 32'h00008001, "lhu_12");
        addVec(1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h80013344, "lw_after_sh");
        addVec(1'b1, 3'b010, 32'h00, 32'hCAFEF00D, 1'b0, 32'h0,        "sw_word0");
`ifdef DMEM_FAULT_CHECK_EN
        addVec(1'b0, 3'b010, 32'h11, 32'h0,        1'b1, 32'h0,        "lw_misaligned");
        addVec(1'b1, 3'b010, 32'(4*DEPTH), 32'h12345678, 1'b1, 32'h0,  "sw_out_of_range");
        addVec(1'b0, 3'b010, 32'h00, 32'h0,        1'b0, 32'hCAFEF00D, "lw_word0_intact");
        addVec(1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'h0,        "undefined_func3");
        addVec(1'b1, 3'b100, 32'h10, 32'h0,        1'b1, 32'h0,        "store_bu_fault");
`else
        addVec(1'b0, 3'b010, 32'h11, 32'h0,        1'b0, 32'h80013344, "lw_forced_align");
        addVec(1'b0, 3'b011, 32'h10, 32'h0,        1'b0, 32'h80013344, "undefined_as_w");
        addVec(1'b0, 3'b010, 32'(4*DEPTH), 32'h0,  1'b0, 32'hCAFEF00D, "lw_wrap");
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, vecs[i].w, vecs[i].f, vecs[i].a, vecs[i].d, vecs[i].name,
                          1'b1, vecs[i].expErr, vecs[i].expData);
        end

        // Reset during the second WAIT cycle of a store (WAIT_CYCLES=3)
        begin
            logic [31:0] oldWord;
            for (int i = 0; i < 4; i++) oldWord[8*i +: 8] = modelMem[1][32'h20 + i];
            @(negedge clk);
            req[1] = 1'b1; we[1] = 1'b1; func3[1] = 3'b010; addr[1] = 32'h20; wdata[1] = ~oldWord;
            @(posedge clk);
            @(posedge clk);
            #2;
            reset[1] = 1'b1;
            req[1]   = 1'b0;
            #1;
            checkOutput("midwait_reset_outputs", {rdata[1][31:2], ready[1], err[1]} | {2'b00, rdata[1][1:0], 28'd0}, 32'd0);
            @(negedge clk);
            @(negedge clk);
            reset[1] = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                checkOutput("midwait_no_ready", {31'd0, ready[1]}, 32'd0);
            end
            applyStimulus(1, 1'b0, 3'b010, 32'h20, 32'd0, "midwait_lw_old", 1'b1, 1'b0, oldWord);
        end

        // Back-to-back loads with req held high (WAIT_CYCLES=0)
        modelAccess(2, 1'b0, 3'b010, 32'h24, 32'd0, mErr, mData);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; func3[2] = 3'b010; addr[2] = 32'h24;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checkOutput("b2b_ready", {31'd0, ready[2]}, {31'd0, ((c % 2) == 0)});
            checkOutput("b2b_rdata", rdata[2], ((c % 2) == 0) ? mData : 32'd0);
        end
        @(negedge clk);
        req[2] = 1'b0;
        @(posedge clk);

        // Randomized traffic against the model on every instance
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 80; n++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH-1));
                applyStimulus(k, 1'($urandom), 3'($urandom), a, $urandom, "random", 1'b0, 1'b0, 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words of storage (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: wait states between request capture and response (0..15).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  1  request valid from the core load/store unit.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port func3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port rdata  output  32  load data, extended to 32 bits; valid only while ready=1.
REQ-011 SHALL have port ready  output  1  one-cycle response strobe.
REQ-012 SHALL have port err  output  1  access fault; valid only while ready=1.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1, SHALL register we, func3, addr and wdata, then move to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-015 In WAIT, SHALL load a down-counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and move to RESP when it reads 0. Total latency from req sampled to ready SHALL be WAIT_CYCLES+1 cycles.
REQ-016 In RESP, SHALL assert ready for exactly one cycle and return to IDLE. A new req SHALL be sampled no earlier than the following IDLE cycle.
REQ-017 The requester SHALL hold req and its operands stable until ready. The block SHALL use only the registered operands, so input changes after capture have no effect.
REQ-018 A store SHALL update memory on the RESP clock edge using byte enables: B writes lane addr[1:0]; H writes lanes {addr[1],0} and {addr[1],1}; W writes all four lanes. Other bytes SHALL be unchanged.
REQ-019 A load SHALL select the addressed byte or half from word addr[31:2], then:
  - B and H sign-extend.
  - BU and HU zero-extend.
  - W passes through unchanged.
REQ-020 Undefined func3 values (011, 110, 111) and BU/HU with we=1 SHALL be faults.
REQ-021 A halfword with addr[0]=1 and a word with addr[1:0]!=0 SHALL be misalignment faults.
REQ-022 addr[31:2] >= DEPTH SHALL be an out-of-range fault.
REQ-023 On any fault, err=1 and rdata=0 during RESP, and memory SHALL NOT be written.
REQ-024 Outside RESP, rdata SHALL be 0 and err SHALL be 0.
REQ-025 A load issued immediately after a store to the same address SHALL return the stored data.

Reset
REQ-026 Asserting reset SHALL force state IDLE, counter 0, ready 0, err 0, rdata 0. This applies in any state, including mid-WAIT; the pending access is discarded and a pending store is not performed.
REQ-027 Memory contents SHALL NOT be affected by reset.
REQ-028 After reset deasserts, the first edge with req=1 SHALL be accepted.

Configuration
REQ-029 With macro DMEM_FAULT_CHECK_EN defined, REQ-020 to REQ-023 SHALL apply as written.
REQ-030 Without DMEM_FAULT_CHECK_EN:
  - err SHALL be constant 0.
  - Misaligned H/W accesses SHALL ignore the offending low address bits (forced alignment).
  - The word index SHALL wrap modulo DEPTH.
  - Undefined func3 values SHALL behave as W.

Structure
REQ-031 A shared package dmem_pkg SHALL hold the func3 size constants and the FSM state enum.
REQ-032 A combinational sub-module dmem_lane_align SHALL produce the store byte enables and lane-shifted write data, and the load lane select plus extension. The top level SHALL hold the FSM, counter, operand registers and storage array.

Verification
REQ-033 With WAIT_CYCLES=1: SW 0xDEADBEEF to 0x10, then LW 0x10. The store SHALL give ready 2 cycles after req with err=0; the load SHALL give rdata=0xDEADBEEF.
REQ-034 SB 0x80 to 0x13 over word 0x11223344 at 0x10. LB 0x13 SHALL return 0xFFFFFF80, LBU 0x13 SHALL return 0x00000080, and LW 0x10 SHALL return 0x80223344.
REQ-035 SH 0x8001 to 0x12, then LH 0x12 -> 0xFFFF8001 and LHU 0x12 -> 0x00008001.
REQ-036 With DMEM_FAULT_CHECK_EN defined:
  - LW 0x11 SHALL give err=1 and rdata=0.
  - SW to byte address 4*DEPTH SHALL give err=1 and leave memory unchanged (checked by readback).
REQ-037 With WAIT_CYCLES=3, asserting reset during the second WAIT cycle of an SW SHALL produce no ready; a subsequent LW SHALL return the old data.
REQ-038 With WAIT_CYCLES=0, back-to-back requests SHALL see ready on every second cycle.
